// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester arbiter that serialises operations onto a shared
//            ALU and returns one captured response at a time.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [5:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;
    logic   r_gnt;
    logic   w_gnt;
    logic   w_any;
    logic   w_illegal;

    always_comb begin
        w_any = |req_valid;
        w_gnt = 1'b0;
        case (req_valid)
            2'b10:   w_gnt = 1'b1;
            2'b11:   w_gnt = (RR_EN != 0) ? ~r_last : 1'b0;
            default: w_gnt = 1'b0;
        endcase
        // Reset wins over a grant that would otherwise happen this cycle
        req_ready = 2'b00;
        if (!rst && (r_state == S_IDLE) && w_any) begin
            req_ready = w_gnt ? 2'b10 : 2'b01;
        end
        w_illegal = (alu_ctrl == 3'b100) || (alu_ctrl == 3'b110) ||
                    (alu_ctrl == 3'b111);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_ctrl   <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        alu_a    <= w_gnt ? req_a[63:32] : req_a[31:0];
                        alu_b    <= w_gnt ? req_b[63:32] : req_b[31:0];
                        alu_ctrl <= w_gnt ? req_op[5:3]  : req_op[2:0];
                        r_gnt    <= w_gnt;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= r_gnt;
                    rsp_err    <= w_illegal;
                    rsp_valid  <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    // Always return through IDLE so no grant overlaps a handshake
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_last    <= r_gnt;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomised scoreboard bench for alu_arbiter with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    logic [1:0]  fp_req_ready;
    logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result, fp_rsp_result;
    logic [2:0]  fp_alu_ctrl;
    logic [3:0]  fp_alu_flags, fp_rsp_flags;
    logic        fp_rsp_valid, fp_rsp_id, fp_rsp_err;

    logic [1:0]  cur_v = 2'b00;
    logic [31:0] cur_a [2] = '{32'd0, 32'd0};
    logic [31:0] cur_b [2] = '{32'd0, 32'd0};
    logic [2:0]  cur_op [2] = '{3'd0, 3'd0};
    logic [1:0]  tpl_v = 2'b00;
    logic [31:0] tpl_a [2] = '{32'd0, 32'd0};
    logic [31:0] tpl_b [2] = '{32'd0, 32'd0};
    logic [2:0]  tpl_op [2] = '{3'd0, 3'd0};
    logic        mode = 1'b0;
    logic        rr_dir = 1'b1;
    logic        rr_drv = 1'b1;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    int   gr_n = 0;
    int   hs_n = 0;
    int   avail = 0;
    logic mdl_last = 1'b1;
    int   fp_n = 0;

    // Reference ALU: {N,Z,C,V} from plain arithmetic; unsupported codes yield zero
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    assign req_valid = cur_v;
    assign req_a     = {cur_a[1], cur_a[0]};
    assign req_b     = {cur_b[1], cur_b[0]};
    assign req_op    = {cur_op[1], cur_op[0]};
    assign rsp_ready = rr_drv;
    assign {alu_flags, alu_result}       = alu_f(alu_a, alu_b, alu_ctrl);
    assign {fp_alu_flags, fp_alu_result} = alu_f(fp_alu_a, fp_alu_b, fp_alu_ctrl);

    alu_arbiter #(.RR_EN(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Fixed-priority instance: both requesters always valid, consumer always ready
    alu_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .rst(rst), .req_valid(2'b11), .req_ready(fp_req_ready),
        .req_a({32'd9, 32'd20}), .req_b({32'd4, 32'd22}), .req_op({3'b001, 3'b000}),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl),
        .alu_result(fp_alu_result), .alu_flags(fp_alu_flags),
        .rsp_valid(fp_rsp_valid), .rsp_ready(1'b1), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_at_edge = rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Requester/consumer driver: reacts to observed acceptances
    initial forever begin
        logic [1:0] gs;
        @(negedge clk);
        gs = req_ready;
        @(posedge clk);
        #1;
        if (mode) begin
            for (int i = 0; i < 2; i++) begin
                if (cur_v[i] && gs[i]) begin
                    cur_a[i] = pick_operand(); cur_b[i] = pick_operand();
                    cur_op[i] = 3'($urandom_range(0, 7));
                    cur_v[i] = 1'($urandom_range(0, 1));
                end else if (cur_v[i] && $urandom_range(0, 15) == 0) begin
                    cur_v[i] = 1'b0;
                end else if (!cur_v[i] && $urandom_range(0, 2) == 0) begin
                    cur_a[i] = pick_operand(); cur_b[i] = pick_operand();
                    cur_op[i] = 3'($urandom_range(0, 7));
                    cur_v[i] = 1'b1;
                end
            end
            rr_drv = ($urandom_range(0, 3) != 0);
        end else begin
            cur_v = tpl_v;
            cur_a = tpl_a; cur_b = tpl_b; cur_op = tpl_op;
            rr_drv = rr_dir;
        end
    end

    // Grant checker: arbitration rules and one-in-flight rule, pushes expectations
    initial forever begin
        logic  g;
        exp_t  e;
        logic [35:0] r;
        logic [31:0] ma, mb;
        logic [2:0]  mo;
        @(negedge clk);
        if (rst_at_edge) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_flags", rsp_flags, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_ctrl", alu_ctrl, 0);
            if (rst) chk("rst_req_ready", req_ready, 0);
        end
        if (rst) begin
            gr_n = 0;
            ma = 32'd0; mb = 32'd0; mo = 3'd0;
        end else begin
            chk("alu_a_hold", alu_a, ma);
            chk("alu_b_hold", alu_b, mb);
            chk("alu_ctrl_hold", alu_ctrl, mo);
            if ((gr_n == hs_n) && (cyc >= avail) && (req_valid != 2'b00)) begin
                if (req_valid == 2'b01)      g = 1'b0;
                else if (req_valid == 2'b10) g = 1'b1;
                else                         g = ~mdl_last;
                chk("grant", req_ready, g ? 2'b10 : 2'b01);
                r = alu_f(cur_a[g], cur_b[g], cur_op[g]);
                e.id = g; e.res = r[31:0]; e.flg = r[35:32];
                e.err = (cur_op[g] == 3'b100) || (cur_op[g] == 3'b110) ||
                        (cur_op[g] == 3'b111);
                e.gcyc = cyc;
                q.push_back(e);
                gr_n++;
                ma = cur_a[g]; mb = cur_b[g]; mo = cur_op[g];
            end else begin
                chk("no_grant", req_ready, 0);
            end
        end
    end

    // Response monitor: pops the scoreboard on each completed handshake
    initial forever begin
        exp_t e;
        logic prev_v;
        @(negedge clk);
        if (rst) begin
            q.delete();
            hs_n = 0; avail = 0; mdl_last = 1'b1; prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 id=%0d expected no response (cycle %0d)",
                             rsp_id, cyc);
                end else begin
                    e = q[0];
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_flags", rsp_flags, e.flg);
                    chk("rsp_err", rsp_err, e.err);
                    if (!prev_v) chk("latency", cyc - e.gcyc, 2);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        mdl_last = e.id;
                        hs_n++;
                        avail = cyc + 1;
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (fp_req_ready != 2'b00) chk("fp_grant", fp_req_ready, 2'b01);
            if (fp_rsp_valid) begin
                chk("fp_rsp_id", fp_rsp_id, 0);
                chk("fp_rsp_result", fp_rsp_result, 42);
                fp_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) ok = 1'b1;
        end
        chk("wait_grant", ok, 1);
    endtask

    task automatic wait_rsp(input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        chk("wait_rsp", ok, 1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;

        // Single add from requester 0
        tpl_a[0] = 32'd5; tpl_b[0] = 32'd7; tpl_op[0] = 3'b000; tpl_v = 2'b01;
        wait_grant(10);
        chk("add_ready", req_ready, 2'b01);
        step(1);
        tpl_v = 2'b00;
        wait_rsp(10);
        chk("add_result", rsp_result, 12);
        chk("add_flags", rsp_flags, 0);
        chk("add_id", rsp_id, 0);
        step(4);

        // Continuous contention under round-robin
        tpl_a[0] = 32'd3;    tpl_b[0] = 32'd3;    tpl_op[0] = 3'b001;
        tpl_a[1] = 32'hF0;   tpl_b[1] = 32'h0F;   tpl_op[1] = 3'b011;
        tpl_v = 2'b11;
        step(30);
        tpl_v = 2'b00;
        step(6);

        // Unsupported code from requester 1
        tpl_a[1] = $urandom; tpl_b[1] = $urandom; tpl_op[1] = 3'b111; tpl_v = 2'b10;
        wait_grant(10);
        step(1);
        tpl_v = 2'b00;
        wait_rsp(10);
        chk("ill_err", rsp_err, 1);
        chk("ill_id", rsp_id, 1);
        chk("ill_result", rsp_result, 0);
        chk("ill_zero", rsp_flags[2], 1);
        step(4);

        // Backpressure with both requesters waiting
        rr_dir = 1'b0;
        tpl_a[0] = $urandom; tpl_b[0] = $urandom; tpl_op[0] = 3'b000; tpl_v = 2'b01;
        wait_grant(10);
        step(1);
        tpl_v = 2'b11;
        wait_rsp(10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_valid, req_ready}, 3'b100);
            @(negedge clk);
        end
        step(1);
        rr_dir = 1'b1;
        step(8);
        tpl_v = 2'b00;
        step(6);

        // Reset while a response is pending; requester 0 must win afterwards
        rr_dir = 1'b0;
        tpl_op[1] = 3'b010; tpl_v = 2'b10;
        wait_rsp(10);
        step(1);
        tpl_v = 2'b11;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        rr_dir = 1'b1;
        wait_grant(10);
        chk("post_rst_grant", req_ready, 2'b01);
        step(10);
        tpl_v = 2'b00;
        step(6);

        // Reset during EXEC discards the operation
        tpl_v = 2'b01;
        wait_grant(10);
        step(1);
        rst = 1'b1;
        tpl_v = 2'b00;
        step(2);
        rst = 1'b0;
        step(6);

        // Randomised traffic
        mode = 1'b1;
        step(600);
        mode = 1'b0;
        tpl_v = 2'b00;
        rr_dir = 1'b1;
        step(12);

        chk("drain_empty", q.size(), 0);
        chk("fp_progress", fp_n > 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
